// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter granting one requester at a time the VGA adapter write port
// Grants are held for at most MAX_HOLD cycles, and every owner change passes through a GAP cycle and then an IDLE cycle.
module vga_plot_arbiter #(
  parameter logic [13:0] MAX_HOLD = 14'd12000
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [3:0]  plot_in,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [11:0] color_in,
  output logic [3:0]  grant,
  output logic        vga_plot,
  output logic [7:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_color,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [13:0] hold_q, hold_d;
  logic [3:0]  grant_q, grant_d;
  logic        plot_q, plot_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  color_q, color_d;
  logic        timeout_q, timeout_d;

  logic [7:0]  x_sl [4];
  logic [7:0]  y_sl [4];
  logic [2:0]  c_sl [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x_sl[i] = x_in[8*i +: 8];
      y_sl[i] = y_in[8*i +: 8];
      c_sl[i] = color_in[3*i +: 3];
    end
  end

  // Scan ptr+1 .. ptr+4 so the most recent owner has the lowest priority.
  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic hold_limit;
  logic exit_own;
  logic forced_exit;

  assign hold_limit  = (hold_q == (MAX_HOLD - 14'd1));
  assign exit_own    = done[owner_q] | ~req[owner_q] | hold_limit;
  // A done in the last allowed cycle counts as a normal exit.
  assign forced_exit = hold_limit & ~done[owner_q] & req[owner_q];

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd3;
      hold_q    <= 14'd0;
      grant_q   <= 4'd0;
      plot_q    <= 1'b0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      color_q   <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          owner_d = pick_idx;
          hold_d  = 14'd0;
        end
      end
      OWN: begin
        hold_d = hold_q + 14'd1;
        if (exit_own) begin
          state_d = GAP;
          ptr_d   = owner_q;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = 4'd0;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    color_d   = color_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (pick_found) grant_d = 4'b0001 << pick_idx;
      end
      OWN: begin
        plot_d  = plot_in[owner_q];
        x_d     = x_sl[owner_q];
        y_d     = y_sl[owner_q];
        color_d = c_sl[owner_q];
        if (!exit_own) grant_d = grant_q;
        if (forced_exit) timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign busy         = |grant_q;
  assign vga_plot     = plot_q;
  assign vga_x        = x_q;
  assign vga_y        = y_q;
  assign vga_color    = color_q;
  assign timeout_flag = timeout_q;

endmodule
